// File: rtl/bldc_pkg.sv
// rtl/bldc_pkg.sv - shared state encoding, phase constants and hall decode for the BLDC commutation block
//   no ports; imported by bldc_commutation_ctrl and hall_debounce
package bldc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEADTIME = 2'd1,
    ST_DRIVE    = 2'd2,
    ST_FAULT    = 2'd3
  } state_t;

  // One-hot phase masks; bit 2 is phase A
  localparam logic [2:0] PHASE_A = 3'b100;
  localparam logic [2:0] PHASE_B = 3'b010;
  localparam logic [2:0] PHASE_C = 3'b001;

  // PWM counter runs 0..PWM_MAX, so duty 511 is never reached by the counter
  localparam logic [8:0] PWM_MAX = 9'd510;

  typedef struct packed {
    logic [2:0] high;
    logic [2:0] low;
  } phase_pair_t;

  function automatic logic hall_valid(input logic [2:0] code);
    return (code != 3'b000) && (code != 3'b111);
  endfunction

  // Forward table gives (high, low); the unlisted phase floats.
  // Reverse swaps high and low and leaves the float phase alone.
  function automatic phase_pair_t hall_decode(input logic [2:0] code, input logic reverse);
    phase_pair_t fwd;
    case (code)
      3'b101:  fwd = '{high: PHASE_A, low: PHASE_B};
      3'b100:  fwd = '{high: PHASE_A, low: PHASE_C};
      3'b110:  fwd = '{high: PHASE_B, low: PHASE_C};
      3'b010:  fwd = '{high: PHASE_B, low: PHASE_A};
      3'b011:  fwd = '{high: PHASE_C, low: PHASE_A};
      3'b001:  fwd = '{high: PHASE_C, low: PHASE_B};
      default: fwd = '{high: 3'b000, low: 3'b000};
    endcase
    if (reverse) begin
      return '{high: fwd.low, low: fwd.high};
    end
    return fwd;
  endfunction

endpackage

// File: rtl/bldc_commutation_ctrl_if.sv
// rtl/bldc_commutation_ctrl_if.sv - control inputs and gate/status outputs of the commutation controller
//   master: drives enable, direction, duty, hall; observes gates, flags, comm_count
//   slave:  the controller side
interface bldc_commutation_ctrl_if;
  logic        enable;
  logic        direction;
  logic [8:0]  duty;
  logic [2:0]  hall;
  logic [2:0]  phase_high;
  logic [2:0]  phase_low;
  logic        hall_fault;
  logic        stall;
  logic [15:0] comm_count;

  modport master (
    output enable, direction, duty, hall,
    input  phase_high, phase_low, hall_fault, stall, comm_count
  );

  modport slave (
    input  enable, direction, duty, hall,
    output phase_high, phase_low, hall_fault, stall, comm_count
  );
endinterface

// File: rtl/hall_debounce.sv
// rtl/hall_debounce.sv - 2-flop hall synchronizer plus stability debounce
//   clk, reset     : clock, async active-high reset
//   hall           : raw hall inputs (asynchronous)
//   accepted       : last accepted hall code (000 after reset)
//   accept_strobe  : one-cycle pulse when accepted changes
//   settled        : set by the first acceptance after reset
module hall_debounce
  import bldc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] hall,
  output logic [2:0] accepted,
  output logic       accept_strobe,
  output logic       settled
);

  logic [2:0] hall_meta;
  logic [2:0] hall_sync;
  logic [2:0] candidate;   // hall_sync one cycle ago, detects glitches
  logic [3:0] stable_cnt;
  logic [3:0] stable_cnt_nxt;

  // A value different from last cycle restarts the run at 1
  assign stable_cnt_nxt = (hall_sync == candidate) ? stable_cnt + 4'd1 : 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hall_meta     <= 3'b000;
      hall_sync     <= 3'b000;
      candidate     <= 3'b000;
      stable_cnt    <= 4'd0;
      accepted      <= 3'b000;
      accept_strobe <= 1'b0;
      settled       <= 1'b0;
    end else begin
      hall_meta     <= hall;
      hall_sync     <= hall_meta;
      candidate     <= hall_sync;
      accept_strobe <= 1'b0;
      if (hall_sync == accepted) begin
        stable_cnt <= 4'd0;
      end else if (stable_cnt_nxt >= 4'(DEBOUNCE_CYCLES)) begin
        accepted      <= hall_sync;
        accept_strobe <= 1'b1;
        settled       <= 1'b1;
        stable_cnt    <= 4'd0;
      end else begin
        stable_cnt <= stable_cnt_nxt;
      end
    end
  end

endmodule

// File: rtl/bldc_commutation_ctrl.sv
// rtl/bldc_commutation_ctrl.sv - six-step BLDC commutation with deadtime, PWM, hall fault and stall detect
//   clk, reset : clock, async active-high reset
//   bus        : enable, direction, duty, hall in; phase_high, phase_low, hall_fault, stall, comm_count out
module bldc_commutation_ctrl
  import bldc_pkg::*;
#(
  parameter int unsigned DEADTIME_CYCLES = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned STALL_CYCLES    = 1048576
) (
  input  logic                   clk,
  input  logic                   reset,
  bldc_commutation_ctrl_if.slave bus
);

  localparam int STALL_W = $clog2(STALL_CYCLES + 1);

  logic [2:0]         accepted;
  logic               accept_strobe;
  logic               settled;
  logic               code_valid;

  state_t             state, next_state;
  logic [7:0]         dead_cnt;
  logic [STALL_W-1:0] stall_cnt;
  logic [8:0]         pwm_cnt;
  logic               pwm_on;
  logic [2:0]         drive_code, drive_code_nxt;
  logic               drive_dir, drive_dir_nxt;
  logic               hall_evt, stall_evt;
  phase_pair_t        decoded;
  logic [2:0]         phase_high_d, phase_low_d;
  logic [2:0]         phase_high_q, phase_low_q;
  logic               hall_fault_q, stall_q;
  logic [15:0]        comm_count_q;

  hall_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_hall_debounce (
    .clk           (clk),
    .reset         (reset),
    .hall          (bus.hall),
    .accepted      (accepted),
    .accept_strobe (accept_strobe),
    .settled       (settled)
  );

  assign code_valid = hall_valid(accepted);
  assign pwm_on     = (pwm_cnt < bus.duty);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // enable low wins over every other condition, including a same-cycle code change
  always_comb begin
    next_state = state;
    hall_evt   = 1'b0;
    stall_evt  = 1'b0;
    if (!bus.enable) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (settled) begin
            if (code_valid) begin
              next_state = ST_DEADTIME;
            end else begin
              next_state = ST_FAULT;
              hall_evt   = 1'b1;
            end
          end
        end
        ST_DEADTIME: begin
          if (!code_valid) begin
            next_state = ST_FAULT;
            hall_evt   = 1'b1;
          end else if (dead_cnt == 8'(DEADTIME_CYCLES - 1)) begin
            next_state = ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (!code_valid) begin
            next_state = ST_FAULT;
            hall_evt   = 1'b1;
          end else if (bus.duty != 9'd0 && stall_cnt == STALL_W'(STALL_CYCLES - 1)) begin
            next_state = ST_FAULT;
            stall_evt  = 1'b1;
          end else if (accept_strobe || (bus.direction != drive_dir)) begin
            next_state = ST_DEADTIME;
          end
        end
        ST_FAULT: next_state = ST_FAULT;
        default:  next_state = ST_IDLE;
      endcase
    end
  end

  // Gate values are computed for the state being entered so the registered
  // outputs line up with the state register rather than lagging it.
  always_comb begin
    drive_code_nxt = drive_code;
    drive_dir_nxt  = drive_dir;
    if (state != ST_DRIVE && next_state == ST_DRIVE) begin
      drive_code_nxt = accepted;
      drive_dir_nxt  = bus.direction;
    end
    decoded      = hall_decode(drive_code_nxt, drive_dir_nxt);
    phase_high_d = 3'b000;
    phase_low_d  = 3'b000;
    if (next_state == ST_DRIVE) begin
      phase_high_d = decoded.high & {3{pwm_on}};
      phase_low_d  = decoded.low;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drive_code   <= 3'b000;
      drive_dir    <= 1'b0;
      phase_high_q <= 3'b000;
      phase_low_q  <= 3'b000;
      pwm_cnt      <= 9'd0;
      dead_cnt     <= 8'd0;
      stall_cnt    <= '0;
      hall_fault_q <= 1'b0;
      stall_q      <= 1'b0;
      comm_count_q <= 16'd0;
    end else begin
      drive_code   <= drive_code_nxt;
      drive_dir    <= drive_dir_nxt;
      phase_high_q <= phase_high_d;
      phase_low_q  <= phase_low_d;
      pwm_cnt      <= (pwm_cnt == PWM_MAX) ? 9'd0 : pwm_cnt + 9'd1;
      dead_cnt     <= (state == ST_DEADTIME) ? dead_cnt + 8'd1 : 8'd0;
      // Held at zero outside DRIVE, so it starts from zero on every entry
      if (state != ST_DRIVE) begin
        stall_cnt <= '0;
      end else if (bus.duty != 9'd0) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (!bus.enable) begin
        hall_fault_q <= 1'b0;
        stall_q      <= 1'b0;
      end else begin
        if (hall_evt)  hall_fault_q <= 1'b1;
        if (stall_evt) stall_q      <= 1'b1;
      end
      if (accept_strobe && code_valid && state != ST_FAULT) begin
        comm_count_q <= comm_count_q + 16'd1;
      end
    end
  end

  assign bus.phase_high = phase_high_q;
  assign bus.phase_low  = phase_low_q;
  assign bus.hall_fault = hall_fault_q;
  assign bus.stall      = stall_q;
  assign bus.comm_count = comm_count_q;

endmodule

// File: tb/tb_bldc_commutation_ctrl.sv
// tb/tb_bldc_commutation_ctrl.sv - directed self-checking bench for bldc_commutation_ctrl
module tb_bldc_commutation_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bldc_commutation_ctrl_if bus ();
  bldc_commutation_ctrl_if bus_stall ();

  // Second instance with a short stall limit shares the same stimulus
  assign bus_stall.enable    = bus.enable;
  assign bus_stall.direction = bus.direction;
  assign bus_stall.duty      = bus.duty;
  assign bus_stall.hall      = bus.hall;

  bldc_commutation_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  bldc_commutation_ctrl #(.STALL_CYCLES(100)) dut_stall (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_stall.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  assert property (@(posedge clk) disable iff (reset) (bus.phase_high & bus.phase_low) == 3'b000)
    else $error("FAIL shoot_through high=%b low=%b", bus.phase_high, bus.phase_low);
  assert property (@(posedge clk) disable iff (reset) (bus_stall.phase_high & bus_stall.phase_low) == 3'b000)
    else $error("FAIL shoot_through_stall high=%b low=%b", bus_stall.phase_high, bus_stall.phase_low);

  int zeros;
  int bad;
  int high_on;
  int high_other;
  int low_bad;

  initial begin
    reset         = 1'b1;
    bus.enable    = 1'b1;
    bus.direction = 1'b0;
    bus.duty      = 9'd511;
    bus.hall      = 3'b101;
    step(2);
    check("rst_high",  {29'd0, bus.phase_high}, 32'd0);
    check("rst_low",   {29'd0, bus.phase_low}, 32'd0);
    check("rst_comm",  {16'd0, bus.comm_count}, 32'd0);
    check("rst_fault", {31'd0, bus.hall_fault}, 32'd0);
    check("rst_stall", {31'd0, bus.stall}, 32'd0);

    // Startup: 2 sync + 4 debounce + 1 + 8 deadtime
    reset = 1'b0;
    step(14);
    check("startup_off_at_14", {26'd0, bus.phase_high, bus.phase_low}, 32'd0);
    step(1);
    check("startup_high", {29'd0, bus.phase_high}, 32'b100);
    check("startup_low",  {29'd0, bus.phase_low}, 32'b010);
    check("startup_comm", {16'd0, bus.comm_count}, 32'd1);

    // Commutation 101 -> 100
    step(5);
    bus.hall = 3'b100;
    zeros = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (bus.phase_high == 3'b000 && bus.phase_low == 3'b000) zeros++;
      if (k == 6) check("comm_pre_edge", {26'd0, bus.phase_high, bus.phase_low}, {26'd0, 6'b100010});
      if (k == 7) check("comm_gap_start", {26'd0, bus.phase_high, bus.phase_low}, 32'd0);
      if (k == 15) begin
        check("comm_new_high", {29'd0, bus.phase_high}, 32'b100);
        check("comm_new_low",  {29'd0, bus.phase_low}, 32'b001);
      end
    end
    check("comm_gap_len", zeros, 8);
    check("comm_count_2", {16'd0, bus.comm_count}, 32'd2);

    // Back to 101
    bus.hall = 3'b101;
    step(20);
    check("back_high", {29'd0, bus.phase_high}, 32'b100);
    check("back_low",  {29'd0, bus.phase_low}, 32'b010);
    check("back_comm", {16'd0, bus.comm_count}, 32'd3);

    // Reverse direction with hall 101
    bus.direction = 1'b1;
    step(1);
    check("rev_gap", {26'd0, bus.phase_high, bus.phase_low}, 32'd0);
    step(11);
    check("rev_high", {29'd0, bus.phase_high}, 32'b010);
    check("rev_low",  {29'd0, bus.phase_low}, 32'b100);

    // Two-cycle glitch must be ignored
    bus.hall = 3'b100;
    step(2);
    bus.hall = 3'b101;
    bad = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (bus.phase_high != 3'b010 || bus.phase_low != 3'b100) bad++;
    end
    check("glitch_outputs", bad, 0);
    check("glitch_comm", {16'd0, bus.comm_count}, 32'd3);

    // Invalid code 111 in DRIVE
    bus.hall = 3'b111;
    step(10);
    check("fault_gates", {26'd0, bus.phase_high, bus.phase_low}, 32'd0);
    check("fault_flag",  {31'd0, bus.hall_fault}, 32'd1);
    check("fault_comm",  {16'd0, bus.comm_count}, 32'd3);

    // Clear through enable low; 101 is accepted while idle
    bus.enable    = 1'b0;
    bus.hall      = 3'b101;
    bus.direction = 1'b0;
    bus.duty      = 9'd256;
    step(1);
    check("fault_cleared", {31'd0, bus.hall_fault}, 32'd0);
    step(10);
    check("idle_comm", {16'd0, bus.comm_count}, 32'd4);
    check("idle_gates", {26'd0, bus.phase_high, bus.phase_low}, 32'd0);

    // Re-enable: both instances reach DRIVE after edge 9; short-limit one stalls at edge 109
    bus.enable = 1'b1;
    high_on    = 0;
    high_other = 0;
    low_bad    = 0;
    for (int k = 1; k <= 530; k++) begin
      step(1);
      if (k == 108) check("stall_not_yet", {31'd0, bus_stall.stall}, 32'd0);
      if (k == 109) begin
        check("stall_set", {31'd0, bus_stall.stall}, 32'd1);
        check("stall_gates", {26'd0, bus_stall.phase_high, bus_stall.phase_low}, 32'd0);
      end
      if (k >= 20) begin
        if (bus.phase_high == 3'b100) high_on++;
        else if (bus.phase_high != 3'b000) high_other++;
        if (bus.phase_low != 3'b010) low_bad++;
      end
    end
    check("pwm_on_cycles", high_on, 256);
    check("pwm_other_high", high_other, 0);
    check("pwm_low_steady", low_bad, 0);
    check("main_no_stall", {31'd0, bus.stall}, 32'd0);

    // Mid-DRIVE asynchronous reset
    check("pre_reset_low", {29'd0, bus.phase_low}, 32'b010);
    reset = 1'b1;
    #1;
    check("async_rst_gates", {26'd0, bus.phase_high, bus.phase_low}, 32'd0);
    check("async_rst_comm",  {16'd0, bus.comm_count}, 32'd0);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
